// File: rtl/track_servo_ctrl_pkg.sv
// Shared constants, widths and FSM state encoding for the ball-tracking servo loop.
package track_servo_ctrl_pkg;

    // Default PWM timing and pulse-width limits (25 MHz PClk)
    localparam int PERIOD_CYC = 500000;
    localparam int PW_MIN     = 25000;
    localparam int PW_MAX     = 50000;
    localparam int PW_CENTER  = 37500;

    // Screen geometry
    localparam int SCR_H_CTR = 320;
    localparam int SCR_V_CTR = 240;
    localparam int H_MAX     = 639;
    localparam int V_MAX     = 479;

    // Datapath widths
    localparam int PW_W    = 17;
    localparam int ERR_W   = 13;
    localparam int ERR_V_W = 12;
    localparam int DELTA_W = 20;
    localparam int HCNT_W  = 12;
    localparam int VCNT_W  = 11;

    // Update FSM encoding
    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_CALC   = 2'd2;
    localparam logic [1:0] ST_APPLY  = 2'd3;

endpackage

// File: rtl/track_servo_ctrl_if.sv
// Video-timing / centroid inputs and servo outputs of the tracking controller.
interface track_servo_ctrl_if;
    import track_servo_ctrl_pkg::*;

    logic [HCNT_W-1:0] VtcHCnt;
    logic [VCNT_W-1:0] VtcVCnt;
    logic [HCNT_W-1:0] center_h;
    logic [VCNT_W-1:0] center_v;
    logic              target_valid;
    logic              track_en;
    logic              servo_pan;
    logic              servo_tilt;
    logic [PW_W-1:0]   pan_pw;
    logic [PW_W-1:0]   tilt_pw;
    logic              locked;
    logic              lost;

    modport master (
        output VtcHCnt, VtcVCnt, center_h, center_v, target_valid, track_en,
        input  servo_pan, servo_tilt, pan_pw, tilt_pw, locked, lost
    );

    modport slave (
        input  VtcHCnt, VtcVCnt, center_h, center_v, target_valid, track_en,
        output servo_pan, servo_tilt, pan_pw, tilt_pw, locked, lost
    );

endinterface

// File: rtl/track_servo_ctrl_servo_pwm_gen.sv
// One servo PWM channel driven from the shared period counter; the width is
// shadowed at the period boundary so a pulse in flight is never altered.
module servo_pwm_gen
    import track_servo_ctrl_pkg::*;
#(
    parameter int CNT_W  = 19,
    parameter int PERIOD = 500000,
    parameter int PW_RST = 37500
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [PW_W-1:0]  pw_i,
    output logic             pwm_o
);

    localparam int               CMP_W    = (CNT_W > PW_W) ? CNT_W : PW_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [PW_W-1:0] active_q;
    logic            pwm_q;

    // Load the shadow width only on the last count of the period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                active_q <= PW_W'(PW_RST);
        else if (cnt_i == CNT_LAST) active_q <= pw_i;
    end

    // Registered compare; the output lags the counter by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pwm_q <= 1'b0;
        else         pwm_q <= (CMP_W'(cnt_i) < CMP_W'(active_q));
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/track_servo_ctrl.sv
// Ball-tracking servo loop: once per frame samples the centroid, computes the
// error to screen centre, steps pan/tilt pulse widths and drives two PWMs.
module track_servo_ctrl
    import track_servo_ctrl_pkg::*;
#(
    parameter int PERIOD_CYC  = track_servo_ctrl_pkg::PERIOD_CYC,
    parameter int PW_MIN      = track_servo_ctrl_pkg::PW_MIN,
    parameter int PW_MAX      = track_servo_ctrl_pkg::PW_MAX,
    parameter int PW_CENTER   = track_servo_ctrl_pkg::PW_CENTER,
    parameter int DEADBAND    = 16,
    parameter int GAIN_SHIFT  = 2,
    parameter int STEP_CYC    = 8,
    parameter bit INV_H       = 1'b0,
    parameter bit INV_V       = 1'b0,
    parameter int SAMPLE_LINE = 480
) (
    input  logic               PClk,
    input  logic               RstN,
    track_servo_ctrl_if.slave  trk
);

    localparam int CNT_W = $clog2(PERIOD_CYC);
    localparam int SUM_W = DELTA_W + 1;

    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(PERIOD_CYC - 1);
    localparam logic signed [SUM_W-1:0]   PW_MIN_S = SUM_W'(PW_MIN);
    localparam logic signed [SUM_W-1:0]   PW_MAX_S = SUM_W'(PW_MAX);
    localparam logic signed [DELTA_W-1:0] STEP_S   = DELTA_W'(STEP_CYC);
    localparam logic [ERR_W-1:0]          DB_U     = ERR_W'(DEADBAND);
    localparam logic [VCNT_W-1:0]         SAMPLE_V = VCNT_W'(SAMPLE_LINE);
    localparam logic [HCNT_W-1:0]         H_MAX_U  = HCNT_W'(H_MAX);
    localparam logic [VCNT_W-1:0]         V_MAX_U  = VCNT_W'(V_MAX);
    localparam logic signed [ERR_W-1:0]   H_CTR_S  = ERR_W'(SCR_H_CTR);
    localparam logic signed [ERR_V_W-1:0] V_CTR_S  = ERR_V_W'(SCR_V_CTR);

    // |err| <= DEADBAND
    function automatic logic in_deadband(input logic signed [ERR_W-1:0] err);
        logic [ERR_W-1:0] mag;
        mag = err[ERR_W-1] ? $unsigned(-err) : $unsigned(err);
        return (mag <= DB_U);
    endfunction

    // Proportional step with deadband; the sum is one bit wider than the
    // delta so it cannot overflow before saturation to [PW_MIN, PW_MAX].
    function automatic logic [PW_W-1:0] axis_next(input logic [PW_W-1:0]        pw,
                                                 input logic signed [ERR_W-1:0] err);
        logic signed [ERR_W-1:0]   shifted;
        logic signed [DELTA_W-1:0] delta;
        logic signed [SUM_W-1:0]   sum;
        logic [PW_W-1:0]           result;
        shifted = err >>> GAIN_SHIFT;
        delta   = DELTA_W'(shifted) * STEP_S;
        sum     = $signed({{(SUM_W-PW_W){1'b0}}, pw}) + SUM_W'(delta);
        if (in_deadband(err))   result = pw;
        else if (sum < PW_MIN_S) result = PW_W'(PW_MIN);
        else if (sum > PW_MAX_S) result = PW_W'(PW_MAX);
        else                     result = sum[PW_W-1:0];
        return result;
    endfunction

    logic [1:0]                state_q, state_d;
    logic                      trigger;
    logic                      sample_en, calc_en, apply_en;
    logic [HCNT_W-1:0]         samp_h_q;
    logic [VCNT_W-1:0]         samp_v_q;
    logic                      samp_valid_q;
    logic signed [ERR_W-1:0]   err_h_d, err_h_q;
    logic signed [ERR_V_W-1:0] err_v_d, err_v_q;
    logic signed [ERR_W-1:0]   err_v_ext;
    logic                      upd_en;
    logic [PW_W-1:0]           pan_pw_d, pan_pw_q;
    logic [PW_W-1:0]           tilt_pw_d, tilt_pw_q;
    logic                      locked_d, locked_q;
    logic                      lost_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      pan_pwm, tilt_pwm;

    assign trigger = (trk.VtcVCnt == SAMPLE_V) && (trk.VtcHCnt == '0);

    // FSM state register.
    always_ff @(posedge PClk or negedge RstN) begin
        if (!RstN) state_q <= ST_WAIT;
        else       state_q <= state_d;
    end

    // FSM next state: one pass WAIT->SAMPLE->CALC->APPLY per trigger; triggers outside WAIT are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:   if (trigger) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_CALC;
            ST_CALC:   state_d = ST_APPLY;
            default:   state_d = ST_WAIT;
        endcase
    end

    // FSM output decode into per-step enables.
    always_comb begin
        sample_en = (state_q == ST_SAMPLE);
        calc_en   = (state_q == ST_CALC);
        apply_en  = (state_q == ST_APPLY);
    end

    // Capture the centroid, clamped to the visible area, and its valid flag.
    always_ff @(posedge PClk or negedge RstN) begin
        if (!RstN) begin
            samp_h_q     <= '0;
            samp_v_q     <= '0;
            samp_valid_q <= 1'b0;
        end else if (sample_en) begin
            samp_h_q     <= (trk.center_h > H_MAX_U) ? H_MAX_U : trk.center_h;
            samp_v_q     <= (trk.center_v > V_MAX_U) ? V_MAX_U : trk.center_v;
            samp_valid_q <= trk.target_valid;
        end
    end

    // Signed error against screen centre, optionally inverted per axis.
    always_comb begin
        err_h_d = $signed({1'b0, samp_h_q}) - H_CTR_S;
        err_v_d = $signed({1'b0, samp_v_q}) - V_CTR_S;
        if (INV_H) err_h_d = -err_h_d;
        if (INV_V) err_v_d = -err_v_d;
    end

    // Error registers.
    always_ff @(posedge PClk or negedge RstN) begin
        if (!RstN) begin
            err_h_q <= '0;
            err_v_q <= '0;
        end else if (calc_en) begin
            err_h_q <= err_h_d;
            err_v_q <= err_v_d;
        end
    end

    assign err_v_ext = {err_v_q[ERR_V_W-1], err_v_q};
    assign upd_en    = trk.track_en && samp_valid_q;

    // Next pulse widths and lock status; positions hold unless tracking a valid target.
    always_comb begin
        pan_pw_d  = pan_pw_q;
        tilt_pw_d = tilt_pw_q;
        if (upd_en) begin
            pan_pw_d  = axis_next(pan_pw_q, err_h_q);
            tilt_pw_d = axis_next(tilt_pw_q, err_v_ext);
        end
        locked_d = upd_en && in_deadband(err_h_q) && in_deadband(err_v_ext);
    end

    // Commit widths and flags on the APPLY edge.
    always_ff @(posedge PClk or negedge RstN) begin
        if (!RstN) begin
            pan_pw_q  <= PW_W'(PW_CENTER);
            tilt_pw_q <= PW_W'(PW_CENTER);
            locked_q  <= 1'b0;
            lost_q    <= 1'b0;
        end else if (apply_en) begin
            pan_pw_q  <= pan_pw_d;
            tilt_pw_q <= tilt_pw_d;
            locked_q  <= locked_d;
            lost_q    <= ~samp_valid_q;
        end
    end

    // Free-running PWM period counter shared by both channels.
    always_ff @(posedge PClk or negedge RstN) begin
        if (!RstN)                 cnt_q <= '0;
        else if (cnt_q == CNT_LAST) cnt_q <= '0;
        else                       cnt_q <= cnt_q + CNT_W'(1);
    end

    servo_pwm_gen #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD_CYC),
        .PW_RST (PW_CENTER)
    ) u_pan_pwm (
        .clk_i  (PClk),
        .rst_ni (RstN),
        .cnt_i  (cnt_q),
        .pw_i   (pan_pw_q),
        .pwm_o  (pan_pwm)
    );

    servo_pwm_gen #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD_CYC),
        .PW_RST (PW_CENTER)
    ) u_tilt_pwm (
        .clk_i  (PClk),
        .rst_ni (RstN),
        .cnt_i  (cnt_q),
        .pw_i   (tilt_pw_q),
        .pwm_o  (tilt_pwm)
    );

    assign trk.servo_pan  = pan_pwm;
    assign trk.servo_tilt = tilt_pwm;
    assign trk.pan_pw     = pan_pw_q;
    assign trk.tilt_pw    = tilt_pw_q;
    assign trk.locked     = locked_q;
    assign trk.lost       = lost_q;

endmodule
